vga_fb_wr_ctl: RTL
==================

Name: vga_fb_wr_ctl

Overview:
Write-side scheduler for the frame buffer. Accepts a raster-ordered stream of 6-bit colour codes from the PPU, buffers it in a small FIFO, and generates frame buffer write cycles (ppu_ptr_x, ppu_ptr_y, ppu_DI, CS). Writes issue only in cycles where the write port is granted. Tracks frame boundaries and flags stream desynchronisation. Sits between the PPU pixel output and the frame buffer write port, in the frame buffer write clock domain.

Parameters:
DEPTH, 4, pixel FIFO entries (power of 2, >=2)
FB_W, 256, pixels per line (x wraps at FB_W-1)
FB_H, 240, lines per frame (last line FB_H-1)

Ports:
clk  in  1  write-domain clock
rst  in  1  synchronous reset, active-high
px_valid  in  1  PPU pixel valid
px_ready  out  1  FIFO can accept
px_code  in  6  colour code
px_sof  in  1  qualifies px_code as pixel (0,0) of a frame
wr_gnt  in  1  frame buffer write port available this cycle
ppu_ptr_x  out  8  write column
ppu_ptr_y  out  8  write row
ppu_DI  out  6  write data
CS  out  1  write strobe, one cycle per pixel
frame_done  out  1  one-cycle pulse after pixel (FB_W-1,FB_H-1) is written
sync_err  out  1  sticky desync flag; cleared only by rst
busy  out  1  state != IDLE or FIFO non-empty
vga_vblank  in  1  VGA vertical blank level (used only with option)
fb_bank  out  1  active write bank (0 when option is off)

Behaviour:
- Reset:
  - Synchronous, active-high; rst wins over all simultaneous events.
  - All outputs are 0 while rst is high and in the first cycle after. px_ready is 0 during reset and 1 from the first cycle after rst falls.
  - Reset mid-frame discards FIFO contents and returns to IDLE. No partial CS is emitted.
- FIFO:
  - DEPTH entries of {sof, code}. Push when px_valid && px_ready.
  - px_ready = !full, registered. A push and a pop in the same cycle are both legal when full.
  - Not fall-through.
- Pop:
  - A pop occurs when FIFO is non-empty && wr_gnt && state allows.
  - CS, ppu_ptr_x, ppu_ptr_y and ppu_DI are registered at the pop edge. CS is high for exactly one cycle per popped written pixel.
  - Minimum latency: pixel accepted at edge k produces CS high between edges k+1 and k+2.
- States:
  - IDLE:
    - Head entry with sof=0: pop and discard, no CS, set sync_err.
    - Head entry with sof=1: pop, write at (0,0), set x=1, y=0, go RUN.
  - RUN:
    - Each pop writes at (x,y), then x++.
    - After writing x=FB_W-1: x=0, y++.
    - Writing (FB_W-1,FB_H-1) goes to DONE.
    - Head with sof=1 in RUN (short frame): write at (0,0), restart counters at x=1, y=0, set sync_err, no frame_done.
  - DONE:
    - frame_done=1 for one cycle, no pop, then IDLE.
    - The next frame's sof may already be queued.
- Widths and timing:
  - x and y counters are 8-bit.
  - The y>FB_H-1 state is unreachable; any out-of-range y forces IDLE plus sync_err.
  - wr_gnt low stalls the pop without loss; CS stays low.

Optional Feature:
VGA_FB_DBUF_EN:
- Defined:
  - Entering DONE also sets swap_pend.
  - The controller stays in DONE, with no pops, until a cycle with vga_vblank=1. On that edge fb_bank toggles, swap_pend clears and the state goes to IDLE.
  - frame_done pulses in the cycle fb_bank toggles.
  - The FIFO keeps accepting until full.
- Undefined:
  - fb_bank is tied 0 and vga_vblank is ignored.
  - DONE lasts exactly one cycle.

Decomposition:
- Package vga_fb_pkg:
  - typedef px_code_t (6 bits)
  - typedef fb_coord_t (8 bits)
  - typedef enum fb_wr_state_t {IDLE, RUN, DONE}
  - constants FB_W_DEF=256, FB_H_DEF=240
- Sub-module vga_fb_px_fifo: a parameterised synchronous FIFO, DEPTH x 7 bits. It carries push/pop, full/empty and data only.

Test Plan:
1. Reset then a full frame of 61440 pixels, sof on the first, wr_gnt=1 -> 61440 CS pulses at raster-ordered coordinates; frame_done once, one cycle after the (255,239) CS; sync_err=0.
2. Single pixel code 0x18 with sof, accepted at edge k -> CS=1, ppu_ptr=(0,0), ppu_DI=0x18 between edges k+1 and k+2.
3. wr_gnt held low with px_valid=1 continuously -> 4 pushes then px_ready=0. Releasing wr_gnt -> the 4 pixels are written in order at (0,0)..(3,0).
4. sof re-asserted at pixel (10,5) -> next CS at (0,0), sync_err=1, no frame_done.
5. Pixels without sof after reset -> discarded, no CS, sync_err=1. The first subsequent sof pixel is written at (0,0).
6. VGA_FB_DBUF_EN defined, vga_vblank=0 at frame end -> no pops after (255,239). Raising vga_vblank -> fb_bank 0->1 and frame_done pulse on the same edge.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// Shared types and defaults for the frame buffer write-side scheduler.
//
// Contents:
//   px_code_t     : 6-bit colour code
//   fb_coord_t    : 8-bit frame buffer coordinate
//   fb_wr_state_t : write scheduler states (IDLE, RUN, DONE)
//   px_entry_t    : one FIFO entry {sof, code}
//   FB_W_DEF / FB_H_DEF : default frame geometry (256 x 240)
package vga_fb_pkg;

  typedef logic [5:0] px_code_t;
  typedef logic [7:0] fb_coord_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fb_wr_state_t;

  typedef struct packed {
    logic     sof;
    px_code_t code;
  } px_entry_t;

  localparam int FB_W_DEF = 256;
  localparam int FB_H_DEF = 240;

endpackage

// File: rtl/vga_fb_wr_ctl_if.sv
// Pixel stream + frame buffer write port bundle for vga_fb_wr_ctl.
//
// Signals:
//   px_valid, px_code, px_sof : PPU pixel stream (source -> scheduler)
//   px_ready                  : scheduler can accept a pixel
//   wr_gnt                    : frame buffer write port available this cycle
//   ppu_ptr_x, ppu_ptr_y      : write column / row
//   ppu_DI                    : write data
//   CS                        : write strobe, one cycle per written pixel
//
// Modports:
//   master : the PPU / frame buffer side
//   slave  : the write scheduler
interface vga_fb_wr_ctl_if;
  import vga_fb_pkg::*;

  logic      px_valid;
  logic      px_ready;
  px_code_t  px_code;
  logic      px_sof;
  logic      wr_gnt;
  fb_coord_t ppu_ptr_x;
  fb_coord_t ppu_ptr_y;
  px_code_t  ppu_DI;
  logic      CS;

  modport master (
    output px_valid, px_code, px_sof, wr_gnt,
    input  px_ready, ppu_ptr_x, ppu_ptr_y, ppu_DI, CS
  );

  modport slave (
    input  px_valid, px_code, px_sof, wr_gnt,
    output px_ready, ppu_ptr_x, ppu_ptr_y, ppu_DI, CS
  );

endinterface

// File: rtl/vga_fb_px_fifo.sv
// Synchronous pixel FIFO, DEPTH entries of W bits, registered storage.
// Data pushed at edge k is visible at dout after edge k (no fall-through).
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   push, din   : write request and data (ignored when full unless popping)
//   pop, dout   : read request and head-of-queue data
//   full, empty : occupancy flags, decoded from registered count
module vga_fb_px_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: storage has no reset; only pointers/count are reset, which is
  // enough to make stale entries unreachable and keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_fb_wr_ctl.sv
// Frame buffer write-side scheduler. Buffers the PPU raster pixel stream in
// a small FIFO and issues one write cycle (CS + coordinates + data) per
// pixel in cycles where the write port is granted. Tracks frame boundaries
// and raises a sticky sync_err on stream desynchronisation.
//
// Optional build macro: VGA_FB_DBUF_EN
//   defined   : double buffering; DONE waits for vga_vblank, then toggles
//               fb_bank and pulses frame_done on the same edge.
//   undefined : fb_bank tied 0, vga_vblank ignored, DONE lasts one cycle.
//
// Ports:
//   clk, rst   : write-domain clock, synchronous active-high reset
//   bus        : pixel stream + write port (vga_fb_wr_ctl_if.slave)
//   frame_done : one-cycle pulse after the last pixel of a frame is written
//   sync_err   : sticky desync flag, cleared only by rst
//   busy       : state != IDLE or FIFO non-empty
//   vga_vblank : VGA vertical blank level (double-buffer build only)
//   fb_bank    : active write bank
module vga_fb_wr_ctl
  import vga_fb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int FB_W  = FB_W_DEF,
  parameter int FB_H  = FB_H_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  vga_fb_wr_ctl_if.slave        bus,
  output logic                  frame_done,
  output logic                  sync_err,
  output logic                  busy,
  input  logic                  vga_vblank,
  output logic                  fb_bank
);

  localparam fb_coord_t X_MAX = fb_coord_t'(FB_W - 1);
  localparam fb_coord_t Y_MAX = fb_coord_t'(FB_H - 1);

  fb_wr_state_t state, state_nx;
  fb_coord_t    x, y, x_nx, y_nx;
  fb_coord_t    wr_x, wr_y;
  px_entry_t    head, in_entry;
  logic         full, empty, pop;
  logic         ready_en;
  logic         cs_nx, done_nx, set_err;

`ifdef VGA_FB_DBUF_EN
  logic swap_pend;
`endif

  assign in_entry = '{sof: bus.px_sof, code: bus.px_code};

  // Derived from registers only: ready_en holds it low through reset and
  // releases it on the first edge after rst falls.
  assign bus.px_ready = ready_en && !full;
  assign busy         = (state != IDLE) || !empty;

  vga_fb_px_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(px_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.px_valid && bus.px_ready),
    .din   (in_entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    x_nx     = x;
    y_nx     = y;
    wr_x     = x;
    wr_y     = y;
    pop      = 1'b0;
    cs_nx    = 1'b0;
    done_nx  = 1'b0;
    set_err  = 1'b0;

    case (state)
      IDLE: begin
        if (!empty && bus.wr_gnt) begin
          pop = 1'b1;
          if (head.sof) begin
            cs_nx    = 1'b1;
            wr_x     = '0;
            wr_y     = '0;
            x_nx     = fb_coord_t'(1);
            y_nx     = '0;
            state_nx = RUN;
          end else begin
            // Mid-frame pixel with no frame start seen: drop it.
            set_err = 1'b1;
          end
        end
      end

      RUN: begin
        if (y > Y_MAX) begin
          state_nx = IDLE;
          set_err  = 1'b1;
        end else if (!empty && bus.wr_gnt) begin
          pop   = 1'b1;
          cs_nx = 1'b1;
          if (head.sof) begin
            // Short frame: restart at the origin, no frame_done.
            wr_x    = '0;
            wr_y    = '0;
            x_nx    = fb_coord_t'(1);
            y_nx    = '0;
            set_err = 1'b1;
          end else if (x == X_MAX) begin
            x_nx = '0;
            if (y == Y_MAX) state_nx = DONE;
            else            y_nx = y + 1'b1;
          end else begin
            x_nx = x + 1'b1;
          end
        end
      end

      DONE: begin
`ifdef VGA_FB_DBUF_EN
        if (swap_pend && vga_vblank) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
`else
        state_nx = IDLE;
        done_nx  = 1'b1;
`endif
      end

      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      bus.CS        <= 1'b0;
      bus.ppu_ptr_x <= '0;
      bus.ppu_ptr_y <= '0;
      bus.ppu_DI    <= '0;
      frame_done    <= 1'b0;
      sync_err      <= 1'b0;
      ready_en      <= 1'b0;
    end else begin
      state      <= state_nx;
      x          <= x_nx;
      y          <= y_nx;
      bus.CS     <= cs_nx;
      frame_done <= done_nx;
      ready_en   <= 1'b1;
      if (cs_nx) begin
        bus.ppu_ptr_x <= wr_x;
        bus.ppu_ptr_y <= wr_y;
        bus.ppu_DI    <= head.code;
      end
      if (set_err) sync_err <= 1'b1;
    end
  end

`ifdef VGA_FB_DBUF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      swap_pend <= 1'b0;
      fb_bank   <= 1'b0;
    end else if (state != DONE && state_nx == DONE) begin
      swap_pend <= 1'b1;
    end else if (done_nx) begin
      swap_pend <= 1'b0;
      fb_bank   <= ~fb_bank;
    end
  end
`else
  logic unused_vblank;
  assign unused_vblank = vga_vblank;
  assign fb_bank       = 1'b0;
`endif

endmodule
